// File: rtl/nmea_pkg.sv
// Shared NMEA constants, FSM state type and ASCII helpers for the GLL transmit path.
// The checksum option (NMEA_GLL_CHECKSUM_EN) selects between the two sentence lengths below.
package nmea_pkg;

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;
   localparam logic [7:0] CH_N      = 8'h4E;
   localparam logic [7:0] CH_S      = 8'h53;
   localparam logic [7:0] CH_E      = 8'h45;
   localparam logic [7:0] CH_W      = 8'h57;

   localparam logic [15:0] TALKER = "GP";
   localparam logic [23:0] GLL_ID = "GLL";

   localparam int LAT_DEG_MAX_DEF = 89;
   localparam int LON_DEG_MAX_DEF = 179;
   localparam int SUBMIN_MAX_DEF  = 599999;

   localparam int LEN_CSUM   = 36;
   localparam int LEN_NOCSUM = 33;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      CONVERT,
      SEND,
      GAP,
      WAIT,
      FINISH
   } gll_state_t;

   function automatic logic [7:0] dig_ascii(input logic [3:0] d);
      return {4'h3, d};
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/nmea_gll_tx_if.sv
// Byte handshake between the sentence formatter (master) and the UART transmitter (slave).
interface nmea_gll_tx_if;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       tx_busy;

   modport master (output tx_data, output tx_send, input  tx_busy);
   modport slave  (input  tx_data, input  tx_send, output tx_busy);
endinterface

// File: rtl/nmea_bin2dec.sv
// 24-bit binary to 6-digit BCD, sequential double-dabble with a fixed 24-cycle conversion.
// done stays high from the end of a conversion until the next go.
module nmea_bin2dec (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic [23:0] bin,
   output logic        done,
   output logic [23:0] bcd
);

   logic [23:0] r_shift;
   logic [23:0] r_bcd;
   logic [4:0]  r_cnt;
   logic        r_active;
   logic        r_done;
   logic [19:0] w_adj;

   // The top digit never reaches 5 for results below 10^6, so only the lower five are adjusted.
   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_adj = r_bcd[19:0];
      for (int i = 0; i < 5; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift  <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else if (go) begin
         r_shift  <= bin;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b1;
         r_done   <= 1'b0;
      end else if (r_active) begin
         r_bcd   <= {r_bcd[22:20], w_adj, r_shift[23]};
         r_shift <= {r_shift[22:0], 1'b0};
         r_cnt   <= r_cnt + 5'd1;
         if (r_cnt == 5'd23) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
         end
      end
   end

   assign done = r_done;
   assign bcd  = r_bcd;

endmodule

// File: rtl/nmea_gll_tx.sv
// Formats a lat/lon fix as "$GPGLL,DDMM.MMMM,N,DDDMM.MMMM,W*HH\r\n" and streams it to the UART.
// Define NMEA_GLL_CHECKSUM_EN to append "*HH"; without it the sentence ends "...,E|W\r\n".
module nmea_gll_tx
   import nmea_pkg::*;
#(
   parameter int LAT_DEG_MAX = LAT_DEG_MAX_DEF,
   parameter int LON_DEG_MAX = LON_DEG_MAX_DEF,
   parameter int SUBMIN_MAX  = SUBMIN_MAX_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [6:0]         lat_deg,
   input  logic [23:0]        lat_submins,
   input  logic               lat_north,
   input  logic [7:0]         lon_deg,
   input  logic [23:0]        lon_submins,
   input  logic               lon_east,
   output logic               busy,
   output logic               done,
   output logic               err,
   nmea_gll_tx_if.master      uart
);

`ifdef NMEA_GLL_CHECKSUM_EN
   localparam logic [5:0] LAST_IDX = 6'(LEN_CSUM - 1);
   localparam logic [5:0] STAR_IDX = 6'd31;
   logic [7:0] r_csum, w_csum_nxt;
`else
   localparam logic [5:0] LAST_IDX = 6'(LEN_NOCSUM - 1);
`endif

   gll_state_t  r_state, w_state_nxt;
   logic [5:0]  r_idx, w_idx_nxt;
   logic [6:0]  r_lat_deg;
   logic [23:0] r_lat_sub;
   logic        r_lat_n;
   logic [7:0]  r_lon_deg;
   logic [23:0] r_lon_sub;
   logic        r_lon_e;
   logic        r_busy, r_done, r_err, r_tx_send;
   logic [7:0]  r_tx_data;

   logic        w_done_nxt, w_err_nxt, w_send_nxt, w_capture, w_go, w_range_ok;
   logic        w_lat_done, w_lon_done;
   logic [23:0] w_lat_bcd, w_lon_bcd;
   logic [3:0]  w_lat_t, w_lat_u, w_lon_h, w_lon_t, w_lon_u;
   logic [7:0]  w_char;

   nmea_bin2dec u_lat_conv (.clk(clk), .rst(rst), .go(w_go), .bin(r_lat_sub),
                            .done(w_lat_done), .bcd(w_lat_bcd));
   nmea_bin2dec u_lon_conv (.clk(clk), .rst(rst), .go(w_go), .bin(r_lon_sub),
                            .done(w_lon_done), .bcd(w_lon_bcd));

   assign w_range_ok = (r_lat_deg <= 7'(LAT_DEG_MAX)) && (r_lon_deg <= 8'(LON_DEG_MAX)) &&
                       (r_lat_sub <= 24'(SUBMIN_MAX)) && (r_lon_sub <= 24'(SUBMIN_MAX));

   assign w_lat_t = 4'(r_lat_deg / 7'd10);
   assign w_lat_u = 4'(r_lat_deg % 7'd10);
   assign w_lon_h = 4'(r_lon_deg / 8'd100);
   assign w_lon_t = 4'((r_lon_deg / 8'd10) % 8'd10);
   assign w_lon_u = 4'(r_lon_deg % 8'd10);

   always_comb begin
      w_char = CH_COMMA;
      case (r_idx)
         6'd0:  w_char = CH_DOLLAR;
         6'd1:  w_char = TALKER[15:8];
         6'd2:  w_char = TALKER[7:0];
         6'd3:  w_char = GLL_ID[23:16];
         6'd4:  w_char = GLL_ID[15:8];
         6'd5:  w_char = GLL_ID[7:0];
         6'd7:  w_char = dig_ascii(w_lat_t);
         6'd8:  w_char = dig_ascii(w_lat_u);
         6'd9:  w_char = dig_ascii(w_lat_bcd[23:20]);
         6'd10: w_char = dig_ascii(w_lat_bcd[19:16]);
         6'd11: w_char = CH_DOT;
         6'd12: w_char = dig_ascii(w_lat_bcd[15:12]);
         6'd13: w_char = dig_ascii(w_lat_bcd[11:8]);
         6'd14: w_char = dig_ascii(w_lat_bcd[7:4]);
         6'd15: w_char = dig_ascii(w_lat_bcd[3:0]);
         6'd17: w_char = r_lat_n ? CH_N : CH_S;
         6'd19: w_char = dig_ascii(w_lon_h);
         6'd20: w_char = dig_ascii(w_lon_t);
         6'd21: w_char = dig_ascii(w_lon_u);
         6'd22: w_char = dig_ascii(w_lon_bcd[23:20]);
         6'd23: w_char = dig_ascii(w_lon_bcd[19:16]);
         6'd24: w_char = CH_DOT;
         6'd25: w_char = dig_ascii(w_lon_bcd[15:12]);
         6'd26: w_char = dig_ascii(w_lon_bcd[11:8]);
         6'd27: w_char = dig_ascii(w_lon_bcd[7:4]);
         6'd28: w_char = dig_ascii(w_lon_bcd[3:0]);
         6'd30: w_char = r_lon_e ? CH_E : CH_W;
`ifdef NMEA_GLL_CHECKSUM_EN
         6'd31: w_char = CH_STAR;
         6'd32: w_char = hex_ascii(r_csum[7:4]);
         6'd33: w_char = hex_ascii(r_csum[3:0]);
         6'd34: w_char = CH_CR;
         6'd35: w_char = CH_LF;
`else
         6'd31: w_char = CH_CR;
         6'd32: w_char = CH_LF;
`endif
         default: w_char = CH_COMMA;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_send_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_capture   = 1'b0;
      w_go        = 1'b0;
`ifdef NMEA_GLL_CHECKSUM_EN
      w_csum_nxt  = r_csum;
`endif
      case (r_state)
         IDLE: if (start) begin
            w_capture   = 1'b1;
            w_idx_nxt   = '0;
`ifdef NMEA_GLL_CHECKSUM_EN
            w_csum_nxt  = '0;
`endif
            w_state_nxt = CHECK;
         end
         CHECK: if (w_range_ok) begin
            w_go        = 1'b1;
            w_state_nxt = CONVERT;
         end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
         end
         CONVERT: if (w_lat_done && w_lon_done) w_state_nxt = SEND;
         SEND: if (!uart.tx_busy) begin
            w_send_nxt  = 1'b1;
            w_state_nxt = GAP;
`ifdef NMEA_GLL_CHECKSUM_EN
            // Checksum covers only the bytes strictly between '$' and '*'.
            if (r_idx != 6'd0 && r_idx < STAR_IDX) w_csum_nxt = r_csum ^ w_char;
`endif
         end
         GAP: w_state_nxt = WAIT;
         WAIT: if (!uart.tx_busy) begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = FINISH;
            end else begin
               w_idx_nxt   = r_idx + 6'd1;
               w_state_nxt = SEND;
            end
         end
         FINISH: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_lat_deg <= '0;
         r_lat_sub <= '0;
         r_lat_n   <= 1'b0;
         r_lon_deg <= '0;
         r_lon_sub <= '0;
         r_lon_e   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_tx_send <= 1'b0;
         r_tx_data <= '0;
`ifdef NMEA_GLL_CHECKSUM_EN
         r_csum    <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_busy    <= (w_state_nxt != IDLE);
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_tx_send <= w_send_nxt;
         if (w_send_nxt) r_tx_data <= w_char;
`ifdef NMEA_GLL_CHECKSUM_EN
         r_csum    <= w_csum_nxt;
`endif
         if (w_capture) begin
            r_lat_deg <= lat_deg;
            r_lat_sub <= lat_submins;
            r_lat_n   <= lat_north;
            r_lon_deg <= lon_deg;
            r_lon_sub <= lon_submins;
            r_lon_e   <= lon_east;
         end
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;
   assign uart.tx_send = r_tx_send;
   assign uart.tx_data = r_tx_data;

endmodule
